// File: rtl/sa_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sa_ctrl_pkg
// Shared types and helpers for the input-stationary systolic array sequencer.
//   state_t              : controller FSM states
//   default_out_latency  : weight-consumed to aligned-psum latency, counted in
//                          process_en cycles (weight skew + psum unskew depth)
// -----------------------------------------------------------------------------
package sa_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      PROCESS = 3'd2,
      DRAIN   = 3'd3,
      DONE    = 3'd4
   } state_t;

   function automatic int default_out_latency(input int h, input int w);
      return h + w;
   endfunction

endpackage

// File: rtl/sa_token_pipe.sv
// -----------------------------------------------------------------------------
// sa_token_pipe
// Enable-gated valid shift register. A token entered at din appears at dout
// after DEPTH enabled cycles; cycles with en low freeze the whole pipe, which
// keeps it aligned with an array that is also frozen by process_en.
// Ports:
//   clk, rst : clock, synchronous active-high reset (clears every stage)
//   en       : shift enable
//   din      : token entering stage 0
//   dout     : token in the last stage
//   empty    : no token anywhere in the pipe
// -----------------------------------------------------------------------------
module sa_token_pipe #(
   parameter int DEPTH = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic din,
   output logic dout,
   output logic empty
);

   logic [DEPTH-1:0] stage_reg;
   logic [DEPTH-1:0] stage_next;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         if (gi == 0) begin : g_head
            assign stage_next[gi] = din;
         end else begin : g_body
            assign stage_next[gi] = stage_reg[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         stage_reg <= '0;
      end else if (en) begin
         stage_reg <= stage_next;
      end
   end

   assign dout  = stage_reg[DEPTH-1];
   assign empty = ~|stage_reg;

endmodule

// File: rtl/sa_is_controller.sv
// -----------------------------------------------------------------------------
// sa_is_controller
// Job sequencer for the input-stationary systolic array. Loads ARRAY_WIDTH
// stationary input columns, streams N weight vectors through the array and
// tags every aligned psum vector with an output-buffer write address.
// Ports:
//   clk, rst            : clock, synchronous active-high reset (aborts a job)
//   start               : job start pulse, honoured only in IDLE
//   num_weight_vecs     : N, weight vectors in the job (captured on start)
//   input_base_addr     : first input-column address (captured on start)
//   weight_base_addr    : first weight-vector address (captured on start)
//   out_base_addr       : first output address (captured on start)
//   out_ready           : output buffer has at least two free entries
//   input_rd_en/addr    : input SRAM read port (1-cycle latency)
//   weight_rd_en/addr   : weight SRAM read port (1-cycle latency)
//   input_en            : array loads/shifts its stationary inputs
//   process_en          : array advances weights and psums
//   psum_valid          : aligned psum vector is present this cycle
//   psum_wr_addr        : output-buffer address for that psum vector
//   busy                : high outside IDLE
//   done                : one-cycle pulse at job end
// -----------------------------------------------------------------------------
module sa_is_controller
   import sa_ctrl_pkg::*;
#(
   parameter int ARRAY_HEIGHT = 4,
   parameter int ARRAY_WIDTH  = 4,
   parameter int ADDR_WIDTH   = 10,
   parameter int COUNT_WIDTH  = 16,
   parameter int OUT_LATENCY  = default_out_latency(ARRAY_HEIGHT, ARRAY_WIDTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [COUNT_WIDTH-1:0] num_weight_vecs,
   input  logic [ADDR_WIDTH-1:0]  input_base_addr,
   input  logic [ADDR_WIDTH-1:0]  weight_base_addr,
   input  logic [ADDR_WIDTH-1:0]  out_base_addr,
   input  logic                   out_ready,
   output logic                   input_rd_en,
   output logic [ADDR_WIDTH-1:0]  input_rd_addr,
   output logic                   weight_rd_en,
   output logic [ADDR_WIDTH-1:0]  weight_rd_addr,
   output logic                   input_en,
   output logic                   process_en,
   output logic                   psum_valid,
   output logic [ADDR_WIDTH-1:0]  psum_wr_addr,
   output logic                   busy,
   output logic                   done
);

   // LOAD runs ARRAY_WIDTH read cycles plus one bubble, so the counter must
   // be able to hold the value ARRAY_WIDTH itself.
   localparam int              KW        = $clog2(ARRAY_WIDTH + 1);
   localparam logic [KW-1:0]   LOAD_LAST = KW'(ARRAY_WIDTH);

   state_t                 state_reg, state_next;
   logic [KW-1:0]          k_reg, k_next;
   logic [COUNT_WIDTH-1:0] j_reg, j_next;
   logic [COUNT_WIDTH-1:0] i_reg, i_next;
   logic [COUNT_WIDTH-1:0] n_reg;
   logic [COUNT_WIDTH-1:0] n_last;
   logic [ADDR_WIDTH-1:0]  input_base_reg;
   logic [ADDR_WIDTH-1:0]  weight_base_reg;
   logic [ADDR_WIDTH-1:0]  out_base_reg;
   logic                   input_en_reg;
   logic                   process_en_reg;
   logic                   weight_taken_reg;
   logic                   capture;
   logic                   go;
   logic                   tail;
   logic                   pipe_empty;

   assign n_last = n_reg - 1'b1;

   // out_ready gates the step one cycle ahead of the array: the read issued
   // now is consumed next cycle, which the two-entry output slack absorbs.
   assign go = ((state_reg == PROCESS) || (state_reg == DRAIN)) && out_ready;

   assign input_en   = input_en_reg;
   assign process_en = process_en_reg;
   assign psum_valid = process_en_reg && tail;
   assign psum_wr_addr = psum_valid ? (out_base_reg + ADDR_WIDTH'(i_reg))
                                    : '0;

   // Token pipe tracks which array steps carried a real weight vector, so
   // the drain bubbles never produce psum_valid.
   sa_token_pipe #(
      .DEPTH (OUT_LATENCY)
   ) u_token_pipe (
      .clk   (clk),
      .rst   (rst),
      .en    (process_en_reg),
      .din   (weight_taken_reg),
      .dout  (tail),
      .empty (pipe_empty)
   );

   // ---------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= IDLE;
         k_reg            <= '0;
         j_reg            <= '0;
         i_reg            <= '0;
         n_reg            <= '0;
         input_base_reg   <= '0;
         weight_base_reg  <= '0;
         out_base_reg     <= '0;
         input_en_reg     <= 1'b0;
         process_en_reg   <= 1'b0;
         weight_taken_reg <= 1'b0;
      end else begin
         state_reg        <= state_next;
         k_reg            <= k_next;
         j_reg            <= j_next;
         i_reg            <= i_next;
         input_en_reg     <= input_rd_en;
         process_en_reg   <= go;
         weight_taken_reg <= weight_rd_en;
         if (capture) begin
            n_reg           <= num_weight_vecs;
            input_base_reg  <= input_base_addr;
            weight_base_reg <= weight_base_addr;
            out_base_reg    <= out_base_addr;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Next-state and output decode
   // ---------------------------------------------------------------------
   always_comb begin
      state_next     = state_reg;
      k_next         = k_reg;
      j_next         = j_reg;
      i_next         = i_reg;
      capture        = 1'b0;
      input_rd_en    = 1'b0;
      input_rd_addr  = '0;
      weight_rd_en   = 1'b0;
      weight_rd_addr = '0;
      busy           = (state_reg != IDLE);
      done           = 1'b0;

      if (psum_valid) begin
         i_next = i_reg + 1'b1;
      end

      case (state_reg)
         IDLE: begin
            // A job can only start once the token pipe has fully drained.
            if (start && pipe_empty) begin
               capture = 1'b1;
               k_next  = '0;
               j_next  = '0;
               i_next  = '0;
               if (num_weight_vecs == '0) begin
                  state_next = DONE;
               end else begin
                  state_next = LOAD;
               end
            end
         end

         LOAD: begin
            if (k_reg != LOAD_LAST) begin
               input_rd_en   = 1'b1;
               input_rd_addr = input_base_reg + ADDR_WIDTH'(k_reg);
               k_next        = k_reg + 1'b1;
            end else begin
               // Bubble cycle: the last column lands in the array now, so
               // input_en and process_en never overlap.
               state_next = PROCESS;
            end
         end

         PROCESS: begin
            if (go) begin
               weight_rd_en   = 1'b1;
               weight_rd_addr = weight_base_reg + ADDR_WIDTH'(j_reg);
               j_next         = j_reg + 1'b1;
               if (j_reg == n_last) begin
                  state_next = DRAIN;
               end
            end
         end

         DRAIN: begin
            if (psum_valid && (i_reg == n_last)) begin
               state_next = DONE;
            end
         end

         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_sa_is_controller.sv
// -----------------------------------------------------------------------------
// tb_sa_is_controller
// Directed bench for sa_is_controller (H=W=4, OUT_LATENCY=8). Cycle 0 of each
// job is the cycle in which start is presented; every output is recorded per
// cycle and compared against hand-derived schedules.
// -----------------------------------------------------------------------------
module tb_sa_is_controller;
   import sa_ctrl_pkg::*;

   localparam int AW = 10;
   localparam int CW = 16;
   localparam int NT = 64;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [CW-1:0] num_weight_vecs = '0;
   logic [AW-1:0] input_base_addr = '0;
   logic [AW-1:0] weight_base_addr = '0;
   logic [AW-1:0] out_base_addr = '0;
   logic          out_ready = 1'b1;
   logic          input_rd_en;
   logic [AW-1:0] input_rd_addr;
   logic          weight_rd_en;
   logic [AW-1:0] weight_rd_addr;
   logic          input_en;
   logic          process_en;
   logic          psum_valid;
   logic [AW-1:0] psum_wr_addr;
   logic          busy;
   logic          done;

   int tests    = 0;
   int failures = 0;

   // Signal index: 0 ird, 1 ien, 2 wrd, 3 pen, 4 pv, 5 done, 6 busy
   // Address index: 0 input addr, 1 weight addr, 2 psum addr
   logic          tr_sig [7][NT];
   logic [AW-1:0] tr_addr[3][NT];
   logic          exp_sig [7][NT];
   logic [AW-1:0] exp_addr[3][NT];
   string         nm [7] = '{"ird", "ien", "wrd", "pen", "pv", "done", "busy"};

   sa_is_controller #(
      .ARRAY_HEIGHT (4),
      .ARRAY_WIDTH  (4),
      .ADDR_WIDTH   (AW),
      .COUNT_WIDTH  (CW),
      .OUT_LATENCY  (8)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .num_weight_vecs  (num_weight_vecs),
      .input_base_addr  (input_base_addr),
      .weight_base_addr (weight_base_addr),
      .out_base_addr    (out_base_addr),
      .out_ready        (out_ready),
      .input_rd_en      (input_rd_en),
      .input_rd_addr    (input_rd_addr),
      .weight_rd_en     (weight_rd_en),
      .weight_rd_addr   (weight_rd_addr),
      .input_en         (input_en),
      .process_en       (process_en),
      .psum_valid       (psum_valid),
      .psum_wr_addr     (psum_wr_addr),
      .busy             (busy),
      .done             (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic clear_exp();
      for (int s = 0; s < 7; s++)
         for (int c = 0; c < NT; c++) exp_sig[s][c] = 1'b0;
      for (int a = 0; a < 3; a++)
         for (int c = 0; c < NT; c++) exp_addr[a][c] = '0;
   endtask

   // Mark signal 'which' high over cycles lo..hi; for the strobes that carry
   // an address, the address starts at 'base' and steps by one per cycle.
   task automatic exp_set(input int which, input int lo, input int hi, input int base);
      for (int c = lo; c <= hi; c++) begin
         exp_sig[which][c] = 1'b1;
         if (which == 0) exp_addr[0][c] = AW'(base + c - lo);
         if (which == 2) exp_addr[1][c] = AW'(base + c - lo);
         if (which == 4) exp_addr[2][c] = AW'(base + c - lo);
      end
   endtask

   // Entered just after a rising edge; drives one cycle of inputs, records
   // outputs mid-cycle, and returns just after the following rising edge.
   task automatic run(input int n, input logic [63:0] st_mask,
                      input logic [63:0] nr_mask, input bit scramble);
      for (int c = 0; c < n; c++) begin
         start     = st_mask[c];
         out_ready = !nr_mask[c];
         if (scramble && c >= 1) begin
            num_weight_vecs  = 16'd3;
            input_base_addr  = 10'h155;
            weight_base_addr = 10'h2AA;
            out_base_addr    = 10'h0F0;
         end
         #1;
         tr_sig[0][c]  = input_rd_en;
         tr_sig[1][c]  = input_en;
         tr_sig[2][c]  = weight_rd_en;
         tr_sig[3][c]  = process_en;
         tr_sig[4][c]  = psum_valid;
         tr_sig[5][c]  = done;
         tr_sig[6][c]  = busy;
         tr_addr[0][c] = input_rd_addr;
         tr_addr[1][c] = weight_rd_addr;
         tr_addr[2][c] = psum_wr_addr;
         @(posedge clk);
         #1;
      end
      start     = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic verify(input string tag, input int n);
      int errs_before;
      errs_before = failures;
      for (int c = 0; c < n; c++) begin
         for (int s = 0; s < 7; s++) begin
            chk($sformatf("%s c%0d %s", tag, c, nm[s]),
                32'(tr_sig[s][c]), 32'(exp_sig[s][c]));
            if (exp_sig[s][c] && (s == 0 || s == 2 || s == 4))
               chk($sformatf("%s c%0d %s_addr", tag, c, nm[s]),
                   32'(tr_addr[s/2][c]), 32'(exp_addr[s/2][c]));
         end
      end
      $display("[TB] %s: %0d cycles checked, %0d new errors", tag, n, failures - errs_before);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, " state"}, 32'(dut.state_reg), 32'(IDLE));
      chk({tag, " ird"},   32'(input_rd_en),   32'd0);
      chk({tag, " wrd"},   32'(weight_rd_en),  32'd0);
      chk({tag, " ien"},   32'(input_en),      32'd0);
      chk({tag, " pen"},   32'(process_en),    32'd0);
      chk({tag, " pv"},    32'(psum_valid),    32'd0);
      chk({tag, " busy"},  32'(busy),          32'd0);
      chk({tag, " done"},  32'(done),          32'd0);
      chk({tag, " paddr"}, 32'(psum_wr_addr),  32'd0);
   endtask

   task automatic set_job(input int n, input int ib, input int wb, input int ob);
      num_weight_vecs  = CW'(n);
      input_base_addr  = AW'(ib);
      weight_base_addr = AW'(wb);
      out_base_addr    = AW'(ob);
   endtask

   initial begin
      // Reset state
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      rst = 1'b0;

      // Basic job, N=6, no stalls
      set_job(6, 'h10, 'h20, 'h40);
      clear_exp();
      exp_set(0, 1, 4, 'h10);
      exp_set(1, 2, 5, 0);
      exp_set(2, 6, 11, 'h20);
      exp_set(3, 7, 21, 0);
      exp_set(4, 15, 20, 'h40);
      exp_set(5, 21, 21, 0);
      exp_set(6, 1, 21, 0);
      run(25, 64'h1, 64'h0, 1'b0);
      verify("basic", 25);

      // Same job with out_ready low on cycles 8, 9 and 16
      set_job(6, 'h10, 'h20, 'h40);
      clear_exp();
      exp_set(0, 1, 4, 'h10);
      exp_set(1, 2, 5, 0);
      exp_set(2, 6, 7, 'h20);
      exp_set(2, 10, 13, 'h22);
      exp_set(3, 7, 8, 0);
      exp_set(3, 11, 16, 0);
      exp_set(3, 18, 24, 0);
      exp_set(4, 18, 23, 'h40);
      exp_set(5, 24, 24, 0);
      exp_set(6, 1, 24, 0);
      run(28, 64'h1, 64'h1_0300, 1'b0);
      verify("stall", 28);

      // N=0: done one cycle after start, no activity
      set_job(0, 'h10, 'h20, 'h40);
      clear_exp();
      exp_set(5, 1, 1, 0);
      exp_set(6, 1, 1, 0);
      run(6, 64'h1, 64'h0, 1'b0);
      verify("n0", 6);

      // Reset in PROCESS after three weight reads
      set_job(6, 'h10, 'h20, 'h40);
      clear_exp();
      exp_set(0, 1, 4, 'h10);
      exp_set(1, 2, 5, 0);
      exp_set(2, 6, 8, 'h20);
      exp_set(3, 7, 8, 0);
      exp_set(6, 1, 8, 0);
      run(9, 64'h1, 64'h0, 1'b0);
      verify("prerst", 9);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_idle_outputs("midrst");
      clear_exp();
      run(4, 64'h0, 64'h0, 1'b0);
      verify("postrst", 4);

      // Job after the abort, N=2
      set_job(2, 'h10, 'h20, 'h40);
      clear_exp();
      exp_set(0, 1, 4, 'h10);
      exp_set(1, 2, 5, 0);
      exp_set(2, 6, 7, 'h20);
      exp_set(3, 7, 17, 0);
      exp_set(4, 15, 16, 'h40);
      exp_set(5, 17, 17, 0);
      exp_set(6, 1, 17, 0);
      run(20, 64'h1, 64'h0, 1'b0);
      verify("n2", 20);

      // start held through the whole job while the job inputs change
      set_job(6, 'h10, 'h20, 'h40);
      clear_exp();
      exp_set(0, 1, 4, 'h10);
      exp_set(1, 2, 5, 0);
      exp_set(2, 6, 11, 'h20);
      exp_set(3, 7, 21, 0);
      exp_set(4, 15, 20, 'h40);
      exp_set(5, 21, 21, 0);
      exp_set(6, 1, 21, 0);
      run(26, 64'h3F_FFFF, 64'h0, 1'b1);
      verify("multistart", 26);

      // Address wrap on all three address streams
      set_job(4, 'h3FD, 'h3FE, 'h3FF);
      clear_exp();
      exp_set(0, 1, 4, 'h3FD);
      exp_set(1, 2, 5, 0);
      exp_set(2, 6, 9, 'h3FE);
      exp_set(3, 7, 19, 0);
      exp_set(4, 15, 18, 'h3FF);
      exp_set(5, 19, 19, 0);
      exp_set(6, 1, 19, 0);
      run(22, 64'h1, 64'h0, 1'b0);
      verify("wrap", 22);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
